press_charge: RTL and testbench
===============================

Name: press_charge

Overview:
- Upstream input conditioner for wechat_jump_fsm; sits between the raw board button i_bt and the FSM's press handling.
- Synchronises and debounces the raw button, then measures hold duration as a squeeze level (0-14).
- On release, emits a one-cycle fire strobe with the jump initial velocity.
- The FSM forwards o_squeeze to graphics and o_v_init to jump.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples required to change the debounced level.
- CHARGE_STEP_CYCLES, 1250000: CHARGING cycles per squeeze increment.
- V_BASE, 20: velocity at squeeze 0.
- V_STEP, 10: velocity added per squeeze level.
- MAX_HOLD_CYCLES, 25000000: auto-fire hold time at max squeeze; used only with CHARGE_TIMEOUT_EN.

Ports:
- clk  in  1  block clock, div_res[1] domain.
- rst  in  1  reset; asynchronous, active-low.
- i_bt  in  1  raw button, asynchronous to clk.
- i_en  in  1  FSM ready to accept a charge; high only in the FSM's waiting state.
- o_pressed  out  1  debounced button level.
- o_squeeze  out  4  current squeeze level, 0-14.
- o_v_init  out  8  velocity latched at the last fire.
- o_fire  out  1  one-cycle strobe; o_v_init is valid in that cycle and held afterwards.
- o_charging  out  1  high while in CHARGING.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; o_pressed, o_squeeze, o_fire, o_charging = 0; o_v_init=V_BASE.
  - Sync flops, debounce counter and step counter = 0.
- Synchroniser: 2-flop on i_bt, output s_bt.
- Debounce:
  - Counter clears whenever s_bt==o_pressed.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, o_pressed takes s_bt and the counter clears.
  - Latency from a raw edge to o_pressed = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Edge detection: press_rise and press_fall are derived from o_pressed registered one cycle; each is a single-cycle pulse.
- FSM states: IDLE, CHARGING, FIRE, WAIT_RELEASE.
- IDLE:
  - o_squeeze=0.
  - press_rise with i_en=1 -> CHARGING, step counter=0.
  - A press already held when i_en rises does not start a charge (edge-only).
- CHARGING:
  - o_charging=1; step counter increments every cycle.
  - When the counter equals CHARGE_STEP_CYCLES-1, it wraps to 0 and o_squeeze increments, saturating at 14.
  - o_squeeze=k after k*CHARGE_STEP_CYCLES cycles in CHARGING.
  - press_fall -> FIRE.
  - i_en=0 (abort) -> IDLE with no fire and o_squeeze=0. Abort takes priority over a same-cycle press_fall.
- FIRE (exactly 1 cycle):
  - o_fire=1.
  - o_v_init = min(255, V_BASE + o_squeeze*V_STEP), computed in 12-bit and then saturated. This value is registered on the FIRE entry edge, so it is valid while o_fire=1.
  - o_squeeze holds its value during FIRE.
  - Next state: IDLE if o_pressed=0, else WAIT_RELEASE.
- WAIT_RELEASE: o_squeeze=0; stays until o_pressed=0, then -> IDLE. No new charge can start until then.
- o_v_init changes only in FIRE or on reset.
- Consecutive fires require a full release-then-press.

Optional Feature:
- Macro CHARGE_TIMEOUT_EN.
- Defined:
  - A hold counter runs while in CHARGING with o_squeeze==14.
  - At MAX_HOLD_CYCLES-1 -> FIRE with squeeze 14, then -> WAIT_RELEASE (button still held).
  - The hold counter clears on leaving CHARGING.
- Undefined: no hold counter; charging waits indefinitely for release.

Decomposition:
- Package jump_pkg holds:
  - SQUEEZE_MAX=14 and widths SQUEEZE_W=4, VEL_W=8.
  - State encoding constants ST_IDLE, ST_CHARGING, ST_FIRE, ST_WAIT_RELEASE.
- One sub-module, bt_debounce (synchroniser plus debounce counter; outputs o_pressed, press_rise, press_fall).
- The charge FSM and the velocity computation live in press_charge.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CHARGE_STEP_CYCLES=8, V_BASE=20, V_STEP=10, MAX_HOLD_CYCLES=16.
- Bounce: i_bt toggles every 2 cycles for 20 cycles, then held high -> o_pressed rises exactly 6 cycles after the final rising edge, with no earlier change.
- Normal charge: i_en=1, press held for 40 CHARGING cycles, then release -> o_squeeze=5 and one o_fire pulse with o_v_init=70; o_squeeze=0 the cycle after; o_v_init stays 70.
- Saturation: hold for 200 CHARGING cycles without the macro -> o_squeeze stops at 14; on release o_v_init=160. With V_STEP=20 -> o_v_init=255 (saturated).
- Abort: drop i_en after 20 CHARGING cycles -> state IDLE, o_squeeze=0, no o_fire pulse, o_v_init unchanged.
- Gating: press while i_en=0, raise i_en while still held, then release -> no CHARGING and no o_fire. A subsequent fresh press starts charging normally.
- Reset: assert rst=0 mid-CHARGING asynchronously (between clock edges) -> all outputs at reset values immediately. With CHARGE_TIMEOUT_EN, hold at squeeze 14 for 16 cycles -> o_fire with o_v_init=160, WAIT_RELEASE until the button is released.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared types and constants for the jump press/charge path.
//   SQUEEZE_W / VEL_W : widths of the squeeze level and the jump velocity
//   SQUEEZE_MAX       : saturation point of the squeeze level
//   state_e           : charge FSM state encoding
//   sat_vel()         : clamps a wide velocity sum to the VEL_W range
package jump_pkg;

  localparam int unsigned SQUEEZE_W = 4;
  localparam int unsigned VEL_W     = 8;
  localparam int unsigned SUM_W     = 12;

  localparam logic [SQUEEZE_W-1:0] SQUEEZE_MAX = SQUEEZE_W'(14);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_CHARGING     = 2'd1,
    ST_FIRE         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  // Saturate a SUM_W-bit velocity to the largest VEL_W-bit value.
  function automatic logic [VEL_W-1:0] sat_vel(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] vel_max;
    vel_max = SUM_W'({VEL_W{1'b1}});
    return (sum > vel_max) ? {VEL_W{1'b1}} : sum[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/bt_debounce.sv
// Button synchroniser and debouncer.
//   clk, rst    : clock, asynchronous active-low reset
//   i_bt        : raw button, asynchronous to clk
//   o_pressed   : debounced level (changes after DEBOUNCE_CYCLES stable samples)
//   press_rise  : one-cycle pulse in the first cycle o_pressed is high
//   press_fall  : one-cycle pulse in the first cycle o_pressed is low
module bt_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bt,
  output logic o_pressed,
  output logic press_rise,
  output logic press_fall
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Stability counter: any sample equal to the current level restarts it.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (sync2_q == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      pressed_d = sync2_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Edge pulses are registered alongside the level so they line up with it.
    rise_d = pressed_d & ~pressed_q;
    fall_d = ~pressed_d & pressed_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync1_q   <= i_bt;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign o_pressed  = pressed_q;
  assign press_rise = rise_q;
  assign press_fall = fall_q;

endmodule

// File: rtl/press_charge.sv
// Press-to-charge conditioner ahead of the jump FSM: debounces the button,
// grows a squeeze level while held and fires a velocity strobe on release.
//   clk, rst   : clock, asynchronous active-low reset
//   i_bt       : raw button
//   i_en       : downstream FSM ready to accept a charge
//   o_pressed  : debounced button level
//   o_squeeze  : squeeze level 0..14 (zero outside CHARGING/FIRE)
//   o_v_init   : velocity latched at the last fire
//   o_fire     : one-cycle fire strobe, o_v_init valid in that cycle
//   o_charging : high while charging
// Build option: define CHARGE_TIMEOUT_EN to auto-fire after MAX_HOLD_CYCLES
// at full squeeze; otherwise charging waits for the release indefinitely.
module press_charge
  import jump_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned CHARGE_STEP_CYCLES = 1250000,
  parameter int unsigned V_BASE             = 20,
  parameter int unsigned V_STEP             = 10,
  parameter int unsigned MAX_HOLD_CYCLES    = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_bt,
  input  logic                 i_en,
  output logic                 o_pressed,
  output logic [SQUEEZE_W-1:0] o_squeeze,
  output logic [VEL_W-1:0]     o_v_init,
  output logic                 o_fire,
  output logic                 o_charging
);

`ifdef CHARGE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned STEP_W = (CHARGE_STEP_CYCLES > 1) ? $clog2(CHARGE_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CHARGE_STEP_CYCLES - 1);
  localparam int unsigned HOLD_W = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);

  logic press_rise, press_fall;

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SQUEEZE_W-1:0] squeeze_q, squeeze_d;
  logic [VEL_W-1:0]     v_init_q, v_init_d;
  logic                 fire_q, fire_d;
  logic                 charging_q, charging_d;
  logic [SUM_W-1:0]     vel_sum_c;

  bt_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .i_bt      (i_bt),
    .o_pressed (o_pressed),
    .press_rise(press_rise),
    .press_fall(press_fall)
  );

  // Velocity from the current squeeze; wide enough that only sat_vel clips.
  assign vel_sum_c = SUM_W'(V_BASE) + SUM_W'(squeeze_q) * SUM_W'(V_STEP);

  // Charge FSM next state and registered-output values.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    hold_d    = '0;
    squeeze_d = squeeze_q;
    v_init_d  = v_init_q;
    case (state_q)
      ST_IDLE: begin
        squeeze_d = '0;
        if (press_rise && i_en) begin
          state_d = ST_CHARGING;
          step_d  = '0;
        end
      end
      ST_CHARGING: begin
        // Abort wins over a release in the same cycle.
        if (!i_en) begin
          state_d   = ST_IDLE;
          squeeze_d = '0;
        end else if (press_fall) begin
          state_d  = ST_FIRE;
          v_init_d = sat_vel(vel_sum_c);
        end else if (TIMEOUT_EN && squeeze_q == SQUEEZE_MAX && hold_q == HOLD_LAST) begin
          state_d  = ST_FIRE;
          v_init_d = sat_vel(vel_sum_c);
        end else begin
          if (TIMEOUT_EN && squeeze_q == SQUEEZE_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (squeeze_q != SQUEEZE_MAX) begin
              squeeze_d = squeeze_q + SQUEEZE_W'(1);
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_FIRE: begin
        // Squeeze stays visible for the fire cycle, then clears.
        squeeze_d = '0;
        state_d   = o_pressed ? ST_WAIT_RELEASE : ST_IDLE;
      end
      ST_WAIT_RELEASE: begin
        squeeze_d = '0;
        if (!o_pressed) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        squeeze_d = '0;
      end
    endcase
    fire_d     = (state_d == ST_FIRE);
    charging_d = (state_d == ST_CHARGING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      hold_q     <= '0;
      squeeze_q  <= '0;
      v_init_q   <= VEL_W'(V_BASE);
      fire_q     <= 1'b0;
      charging_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      squeeze_q  <= squeeze_d;
      v_init_q   <= v_init_d;
      fire_q     <= fire_d;
      charging_q <= charging_d;
    end
  end

  assign o_squeeze  = squeeze_q;
  assign o_v_init   = v_init_q;
  assign o_fire     = fire_q;
  assign o_charging = charging_q;

endmodule

// File: tb/tb_press_charge.sv
// Scoreboard bench for press_charge: two instances (V_STEP 10 and 20) share
// the stimulus; expected fires are queued when a press is issued and a
// monitor pops them whenever a fire strobe appears.
module tb_press_charge;

  localparam int unsigned DB = 4;
  localparam int unsigned CS = 8;
  localparam int unsigned VB = 20;
  localparam int unsigned MH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_bt;
  logic       i_en;
  logic       pressed_a, fire_a, charging_a;
  logic [3:0] sq_a;
  logic [7:0] v_a;
  logic       pressed_b, fire_b, charging_b;
  logic [3:0] sq_b;
  logic [7:0] v_b;

  always #5 clk = ~clk;

  press_charge #(
    .DEBOUNCE_CYCLES(DB), .CHARGE_STEP_CYCLES(CS), .V_BASE(VB), .V_STEP(10), .MAX_HOLD_CYCLES(MH)
  ) dut_a (
    .clk(clk), .rst(rst), .i_bt(i_bt), .i_en(i_en), .o_pressed(pressed_a),
    .o_squeeze(sq_a), .o_v_init(v_a), .o_fire(fire_a), .o_charging(charging_a)
  );

  press_charge #(
    .DEBOUNCE_CYCLES(DB), .CHARGE_STEP_CYCLES(CS), .V_BASE(VB), .V_STEP(20), .MAX_HOLD_CYCLES(MH)
  ) dut_b (
    .clk(clk), .rst(rst), .i_bt(i_bt), .i_en(i_en), .o_pressed(pressed_b),
    .o_squeeze(sq_b), .o_v_init(v_b), .o_fire(fire_b), .o_charging(charging_b)
  );

  typedef struct {
    int sq;
    int va;
    int vb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a hold of n raw cycles yields floor((n-1)/CS) squeeze steps,
  // capped at 14; velocity is base + squeeze*step clipped to 255.
  function automatic exp_t model_fire(input int n_hold);
    exp_t e;
    int   s;
    s = (n_hold - 1) / CS;
    if (s > 14) s = 14;
    e.sq = s;
    e.va = (VB + s * 10 > 255) ? 255 : VB + s * 10;
    e.vb = (VB + s * 20 > 255) ? 255 : VB + s * 20;
    return e;
  endfunction

  // Monitor: every fire strobe consumes one expectation; v_init must hold otherwise.
  int last_a = VB;
  int last_b = VB;
  bit after_fire = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_a     = VB;
      last_b     = VB;
      after_fire = 1'b0;
    end else begin
      if (after_fire) check("squeeze_after_fire", int'(sq_a), 0);
      after_fire = 1'b0;
      if (fire_a || fire_b) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fire: got fire with v_init %0d, required no fire (t=%0t)", v_a, $time);
        end else begin
          e = exp_q.pop_front();
          check("fire_pair_b", int'(fire_b), 1);
          check("fire_pair_a", int'(fire_a), 1);
          check("fire_squeeze", int'(sq_a), e.sq);
          check("fire_v_init", int'(v_a), e.va);
          check("fire_v_init_vstep20", int'(v_b), e.vb);
          last_a     = e.va;
          last_b     = e.vb;
          after_fire = 1'b1;
        end
      end else begin
        check("v_init_hold", int'(v_a), last_a);
        check("v_init_hold_vstep20", int'(v_b), last_b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press with optional 1-cycle bounce pulses, hold n cycles, release.
  task automatic press_release(input int n_hold, input int glitches);
    for (int g = 0; g < glitches; g++) begin
      i_bt = 1'b1; tick(1);
      i_bt = 1'b0; tick(1);
    end
    i_bt = 1'b1;
    tick(n_hold);
    i_bt = 1'b0;
    tick(12);
  endtask

  task automatic normal_charge(input int k, input int off, input int glitches);
    exp_q.push_back(model_fire(CS * k + off));
    press_release(CS * k + off, glitches);
  endtask

  task automatic abort_charge(input int d);
    i_en = 1'b1;
    i_bt = 1'b1;
    tick(d);
    i_en = 1'b0;
    tick(2);
    check("abort_charging", int'(charging_a), 0);
    check("abort_squeeze", int'(sq_a), 0);
    i_bt = 1'b0;
    tick(12);
    i_en = 1'b1;
    tick(2);
  endtask

  task automatic gated_press(input int pre, input int held);
    i_en = 1'b0;
    i_bt = 1'b1;
    tick(pre);
    i_en = 1'b1;
    tick(held);
    check("gated_no_charge", int'(charging_a), 0);
    i_bt = 1'b0;
    tick(12);
  endtask

  initial begin
    int k;
    rst  = 1'b0;
    i_bt = 1'b0;
    i_en = 1'b0;
    tick(3);
    check("reset_pressed", int'(pressed_a), 0);
    check("reset_squeeze", int'(sq_a), 0);
    check("reset_fire", int'(fire_a), 0);
    check("reset_charging", int'(charging_a), 0);
    check("reset_v_init", int'(v_a), VB);
    check("reset_v_init_vstep20", int'(v_b), VB);
    rst = 1'b1;
    tick(2);

    // Bounce: 2-cycle pulses never reach the debounce threshold.
    for (int i = 0; i < 10; i++) begin
      i_bt = ~i_bt;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        check("bounce_ignored", int'(pressed_a), 0);
      end
    end
    i_bt = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      check("debounce_early", int'(pressed_a), 0);
    end
    tick(1);
    check("debounce_latency", int'(pressed_a), 1);
    i_bt = 1'b0;
    tick(12);

    // Normal charge: 41-cycle hold gives squeeze 5, velocity 70.
    i_en = 1'b1;
    exp_q.push_back(model_fire(41));
    i_bt = 1'b1;
    tick(41);
    check("charging_mid_hold", int'(charging_a), 1);
    i_bt = 1'b0;
    tick(12);

    // Saturation: long hold caps squeeze at 14.
    exp_q.push_back(model_fire(CS * 25 + 4));
    i_bt = 1'b1;
    tick(CS * 25 + 4);
`ifdef CHARGE_TIMEOUT_EN
    check("timeout_wait_release_charging", int'(charging_a), 0);
    check("timeout_wait_release_squeeze", int'(sq_a), 0);
`else
    check("saturated_charging", int'(charging_a), 1);
    check("saturated_squeeze", int'(sq_a), 14);
`endif
    i_bt = 1'b0;
    tick(12);

    abort_charge(27);
    gated_press(10, 20);
    i_en = 1'b1;
    normal_charge(3, 4, 0);

    // Asynchronous reset between clock edges while charging.
    i_bt = 1'b1;
    tick(30);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_pressed", int'(pressed_a), 0);
    check("async_rst_squeeze", int'(sq_a), 0);
    check("async_rst_fire", int'(fire_a), 0);
    check("async_rst_charging", int'(charging_a), 0);
    check("async_rst_v_init", int'(v_a), VB);
    check("async_rst_v_init_vstep20", int'(v_b), VB);
    i_bt = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);

    // Randomised mix of charges, aborts and gated presses.
    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          k = int'($urandom_range(0, 25));
`ifdef CHARGE_TIMEOUT_EN
          if (k >= 15 && k <= 17) k = 20;
`endif
          i_en = 1'b1;
          normal_charge(k, int'($urandom_range(2, 6)), int'($urandom_range(0, 3)));
        end
        1: abort_charge(int'($urandom_range(9, 40)));
        default: begin
          gated_press(int'($urandom_range(8, 15)), int'($urandom_range(5, 30)));
          i_en = 1'b1;
        end
      endcase
    end

    tick(20);
    check("pending_fires", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
